// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two writeback requesters (ALU = A, load = B)
// share one register-file write port. Grants are combinational with a 1-bit
// round-robin pointer; the granted write is registered into a single output
// stage one cycle later. Writes to R0 are accepted but suppressed.

// Per-requester grant decision: a requester wins when it is valid, the port is
// not stalled, and it is either favoured by the pointer or uncontested.
module rfwa_grant_lane (
  input  logic vld,
  input  logic favoured,
  input  logic other_vld,
  input  logic blocked,
  output logic ready
);
  assign ready = vld & ~blocked & (favoured | ~other_vld);
endmodule

module regfile_write_arbiter #(
  parameter int REG_W  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Valid,
  input  logic [REG_W-1:0]  A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              B_Valid,
  input  logic [REG_W-1:0]  B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Ready,
  input  logic              Freeze,
  output logic [REG_W-1:0]  Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic              RegWrite,
  output logic [REG_W-1:0]  Pending_Reg,
  output logic              Pending_Valid,
  output logic [CNT_W-1:0]  Write_Count
);

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Index 0 is A, index 1 is B.
  wr_req_t [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] req_vld;
  logic    [NUM_REQ-1:0] req_fav;
  logic    [NUM_REQ-1:0] req_rdy;
  logic                  blocked;

  // ptr_q = 0 favours A, 1 favours B.
  logic              ptr_q,       ptr_d;
  logic              pend_vld_q,  pend_vld_d;
  logic [REG_W-1:0]  pend_reg_q,  pend_reg_d;
  logic [REG_W-1:0]  wr_reg_q,    wr_reg_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic              regwrite_q,  regwrite_d;
  logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;

  logic    hs;
  wr_req_t sel;

  assign req[0].rg   = A_Reg;
  assign req[0].data = A_Data;
  assign req[1].rg   = B_Reg;
  assign req[1].data = B_Data;
  assign req_vld     = {B_Valid, A_Valid};
  assign req_fav     = {ptr_q, ~ptr_q};

  // Reset also blocks grants so nothing is accepted in a reset cycle.
  assign blocked = Freeze | Reset;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      rfwa_grant_lane u_lane (
        .vld      (req_vld[i]),
        .favoured (req_fav[i]),
        .other_vld(req_vld[NUM_REQ-1-i]),
        .blocked  (blocked),
        .ready    (req_rdy[i])
      );
    end
  endgenerate

  assign A_Ready = req_rdy[0];
  assign B_Ready = req_rdy[1];

  // Next-state: pointer update, output-stage capture and commit counting.
  always_comb begin
    hs         = |req_rdy;
    sel        = req_rdy[1] ? req[1] : req[0];
    ptr_d      = ptr_q;
    pend_vld_d = 1'b0;
    pend_reg_d = pend_reg_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    regwrite_d = 1'b0;
    wr_cnt_d   = wr_cnt_q;
    if (Reset) begin
      ptr_d      = 1'b0;
      pend_reg_d = '0;
      wr_reg_d   = '0;
      wr_data_d  = '0;
      wr_cnt_d   = '0;
    end else if (hs) begin
      // Favour whoever lost this handshake next time.
      ptr_d      = req_rdy[0];
      pend_vld_d = 1'b1;
      pend_reg_d = sel.rg;
      wr_reg_d   = sel.rg;
      wr_data_d  = sel.data;
      regwrite_d = (sel.rg != '0);
      // Counter moves together with RegWrite so it already reflects the
      // commit in the cycle the write is presented.
      if (sel.rg != '0) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    ptr_q      <= ptr_d;
    pend_vld_q <= pend_vld_d;
    pend_reg_q <= pend_reg_d;
    wr_reg_q   <= wr_reg_d;
    wr_data_q  <= wr_data_d;
    regwrite_q <= regwrite_d;
    wr_cnt_q   <= wr_cnt_d;
  end

  assign Write_Reg     = wr_reg_q;
  assign Write_Data    = wr_data_q;
  assign RegWrite      = regwrite_q;
  assign Pending_Reg   = pend_reg_q;
  assign Pending_Valid = pend_vld_q;
  assign Write_Count   = wr_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps check Ready in-cycle and push
// the expected output-stage contents; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        A_Valid = 1'b0, B_Valid = 1'b0, Freeze = 1'b0;
  logic [3:0]  A_Reg = '0, B_Reg = '0;
  logic [15:0] A_Data = '0, B_Data = '0;
  logic        A_Ready, B_Ready, RegWrite, Pending_Valid;
  logic [3:0]  Write_Reg, Pending_Reg;
  logic [15:0] Write_Data, Write_Count;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .Freeze(Freeze),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data), .RegWrite(RegWrite),
    .Pending_Reg(Pending_Reg), .Pending_Valid(Pending_Valid),
    .Write_Count(Write_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  rg;
    logic [15:0] data;
    logic        we;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en = 1'b0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus. g: 0 = no grant, 1 = A granted, 2 = B granted.
  task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                      input logic bv, input logic [3:0] br, input logic [15:0] bd,
                      input logic frz, input logic rst, input int g);
    exp_t e;
    A_Valid = av; A_Reg = ar; A_Data = ad;
    B_Valid = bv; B_Reg = br; B_Data = bd;
    Freeze = frz; Reset = rst;
    #1;
    chk("A_Ready", 32'(A_Ready), 32'(g == 1));
    chk("B_Ready", 32'(B_Ready), 32'(g == 2));
    if (g != 0) begin
      e.rg   = (g == 1) ? ar : br;
      e.data = (g == 1) ? ad : bd;
      e.we   = (e.rg != 4'd0);
      if (e.we) exp_cnt = exp_cnt + 16'd1;
      e.cnt  = exp_cnt;
      exp_q.push_back(e);
    end
    @(posedge Clk);
    if (rst) exp_cnt = '0;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_cleared(input string tag);
    #3;
    chk({tag, "_RegWrite"},      32'(RegWrite), 32'd0);
    chk({tag, "_Pending_Valid"}, 32'(Pending_Valid), 32'd0);
    chk({tag, "_Write_Count"},   32'(Write_Count), 32'd0);
    chk({tag, "_Write_Reg"},     32'(Write_Reg), 32'd0);
    chk({tag, "_Write_Data"},    32'(Write_Data), 32'd0);
    chk({tag, "_Pending_Reg"},   32'(Pending_Reg), 32'd0);
  endtask

  // Monitor: every output-stage write must match the oldest expectation;
  // cycles without one must not write.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (Pending_Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(Pending_Valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("Write_Reg",   32'(Write_Reg), 32'(e.rg));
          chk("Pending_Reg", 32'(Pending_Reg), 32'(e.rg));
          chk("Write_Data",  32'(Write_Data), 32'(e.data));
          chk("RegWrite",    32'(RegWrite), 32'(e.we));
          chk("Write_Count", 32'(Write_Count), 32'(e.cnt));
        end
      end else begin
        chk("idle_RegWrite", 32'(RegWrite), 32'd0);
      end
    end
  end

  initial begin
    // Reset with both requesters valid: nothing may be granted.
    step(1'b1, 4'd1, 16'h1, 1'b1, 4'd2, 16'h2, 1'b0, 1'b1, 0);
    mon_en = 1'b1;
    step(1'b1, 4'd1, 16'h1, 1'b1, 4'd2, 16'h2, 1'b0, 1'b1, 0);
    chk_cleared("reset");

    // Single requester A: R3 <= 0020, count 1.
    step(1'b1, 4'd3, 16'h0020, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1);
    idle();

    // R0 from B: accepted, not written, count stays.
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 2);
    idle();

    // Contention for 4 cycles, pointer now favours A: A,B,A,B.
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 1);
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 2);
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 1);
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 2);
    idle();

    // Same-register collision after reset: AAAA then BBBB.
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 0);
    chk_cleared("reset2");
    step(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB, 1'b0, 1'b0, 1);
    step(1'b0, 4'd0, 16'h0,    1'b1, 4'd5, 16'hBBBB, 1'b0, 1'b0, 2);
    idle();

    // Freeze: in-flight R4 still commits, A held off 3 cycles, then granted.
    step(1'b1, 4'd4, 16'h0044, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 4'd6, 16'h0066, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 0);
    step(1'b1, 4'd6, 16'h0066, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 0);
    step(1'b1, 4'd6, 16'h0066, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 0);
    step(1'b1, 4'd6, 16'h0066, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1);
    idle();

    // Reset right after a handshake to R7; pointer must favour A afterwards.
    step(1'b1, 4'd7, 16'h0077, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, 1'b1, 0);
    chk_cleared("midreset");
    step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, 1'b0, 1);
    step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, 1'b0, 2);
    idle();
    idle();
    idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
